// File: rtl/sw_pkg.sv
// Shared constants for the switch conditioning path.
// The counter-width helper keeps the per-bit counter legal for the smallest CNT_MAX.
package sw_pkg;

   localparam int SW_WIDTH             = 16;
   localparam int DEBOUNCE_CNT_DEFAULT = 1_000_000;
   localparam int SYNC_STAGES_DEFAULT  = 2;

   function automatic int cnt_width(input int cnt_max);
      return (cnt_max < 2) ? 1 : $clog2(cnt_max);
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchroniser chain, stability counter, clean level and edge pulses.
// 'update' flags the edge on which the clean level will change, so the parent can register an aggregate alongside the pulses.
module debounce_bit
   import sw_pkg::*;
#(
   parameter int CNT_MAX     = DEBOUNCE_CNT_DEFAULT,
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic clean,
   output logic rise,
   output logic fall,
   output logic update
);

   localparam int              CW       = cnt_width(CNT_MAX);
   localparam logic [CW-1:0]   CNT_LAST = CW'(CNT_MAX - 1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic [CW-1:0]          cnt_reg;
   logic                   sync;

   assign sync   = sync_reg[SYNC_STAGES-1];
   assign update = (sync != clean) && (cnt_reg == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
      end
   end

   // Any sample that agrees with the clean level restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
         clean   <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (sync == clean) begin
            cnt_reg <= '0;
         end else if (update) begin
            cnt_reg <= '0;
            clean   <= sync;
            rise    <= sync;
            fall    <= ~sync;
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

endmodule

// File: rtl/switch_debounce.sv
// Debounces the board slide switches into a clean word plus per-bit rise/fall pulses.
// sw_change is registered on the same edge as the pulses it summarises.
module switch_debounce
   import sw_pkg::*;
#(
   parameter int WIDTH       = SW_WIDTH,
   parameter int CNT_MAX     = DEBOUNCE_CNT_DEFAULT,
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_change
);

   logic [WIDTH-1:0] update;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         debounce_bit #(
            .CNT_MAX     (CNT_MAX),
            .SYNC_STAGES (SYNC_STAGES)
         ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .raw    (sw_raw[gi]),
            .clean  (sw_clean[gi]),
            .rise   (sw_rise[gi]),
            .fall   (sw_fall[gi]),
            .update (update[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_change <= 1'b0;
      end else begin
         sw_change <= |update;
      end
   end

endmodule

// File: tb/tb_switch_debounce.sv
// Randomised and directed bench for switch_debounce with CNT_MAX=4, SYNC_STAGES=2.
// The reference model tracks a delayed copy of the pins and a run length of disagreeing samples per bit.
module tb_switch_debounce;

   localparam int W  = 16;
   localparam int CM = 4;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  sw_raw;
   logic [W-1:0]  sw_clean, sw_rise, sw_fall;
   logic          sw_change;

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0]  m_hist [SS];
   int            m_run  [W];
   logic [W-1:0]  m_clean, m_rise, m_fall;
   logic          m_change;

   switch_debounce #(.WIDTH(W), .CNT_MAX(CM), .SYNC_STAGES(SS)) dut (
      .clk       (clk),
      .rst       (rst),
      .sw_raw    (sw_raw),
      .sw_clean  (sw_clean),
      .sw_rise   (sw_rise),
      .sw_fall   (sw_fall),
      .sw_change (sw_change)
   );

   always #5 clk = ~clk;

   // A pin level reaches the debouncer SS edges after it is sampled; the clean
   // level flips once the delayed level has disagreed with it for CM edges in a row.
   function automatic void model_step();
      logic s;
      if (rst) begin
         for (int k = 0; k < SS; k++) m_hist[k] = '0;
         for (int i = 0; i < W; i++) m_run[i] = 0;
         m_clean = '0; m_rise = '0; m_fall = '0; m_change = 1'b0;
      end else begin
         m_rise = '0; m_fall = '0;
         for (int i = 0; i < W; i++) begin
            s = m_hist[SS-1][i];
            if (s != m_clean[i]) begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] == CM) begin
                  m_clean[i] = s;
                  m_rise[i]  = s;
                  m_fall[i]  = ~s;
                  m_run[i]   = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         m_change = |(m_rise | m_fall);
         for (int k = SS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = sw_raw;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic settle(input logic [W-1:0] v, input int n);
      sw_raw = v;
      for (int t = 0; t < n; t++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; sw_raw = 16'hFFFF;
      for (int t = 1; t <= 3; t++) begin
         tick();
         n_cmp++;
         if (sw_clean !== 16'h0000) begin
            n_err++; $display("FAIL reset_hold edge %0d: sw_clean=%h required 0000", t, sw_clean);
         end
      end
      rst = 1'b0;
      for (int t = 1; t <= 7; t++) begin
         tick();
         n_cmp++;
         if ({sw_clean, sw_rise, sw_fall, sw_change} !== {m_clean, m_rise, m_fall, m_change}) begin
            n_err++;
            $display("FAIL reset_model edge %0d: got %h/%h/%h/%b required %h/%h/%h/%b", t,
                     sw_clean, sw_rise, sw_fall, sw_change, m_clean, m_rise, m_fall, m_change);
         end
         if (t == 5) begin
            n_cmp++;
            if (sw_clean !== 16'h0000) begin
               n_err++; $display("FAIL reset_early edge 5: sw_clean=%h required 0000", sw_clean);
            end
         end
         if (t == 6) begin
            n_cmp++;
            if (sw_clean !== 16'hFFFF || sw_rise !== 16'hFFFF || sw_change !== 1'b1) begin
               n_err++;
               $display("FAIL reset_release edge 6: clean=%h rise=%h chg=%b required FFFF FFFF 1",
                        sw_clean, sw_rise, sw_change);
            end
         end
         if (t == 7) begin
            n_cmp++;
            if (sw_rise !== 16'h0000 || sw_change !== 1'b0) begin
               n_err++; $display("FAIL reset_pulse_width edge 7: rise=%h chg=%b required 0000 0", sw_rise, sw_change);
            end
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_single_step();
      settle(16'h0000, 12);
      sw_raw = 16'h0001;
      for (int t = 1; t <= 7; t++) begin
         tick();
         if (t == 6) begin
            n_cmp++;
            if (sw_clean !== 16'h0001 || sw_rise !== 16'h0001 || sw_fall !== 16'h0000 || sw_change !== 1'b1) begin
               n_err++;
               $display("FAIL single_step edge 6: clean=%h rise=%h fall=%h chg=%b required 0001 0001 0000 1",
                        sw_clean, sw_rise, sw_fall, sw_change);
            end
         end else begin
            n_cmp++;
            if (sw_rise !== 16'h0000 || sw_change !== 1'b0 || sw_clean !== ((t > 6) ? 16'h0001 : 16'h0000)) begin
               n_err++;
               $display("FAIL single_step edge %0d: clean=%h rise=%h chg=%b", t, sw_clean, sw_rise, sw_change);
            end
         end
      end
      $display("test_single_step done");
   endtask

   task automatic test_glitch();
      settle(16'h0000, 12);
      sw_raw = 16'h0002;
      for (int t = 1; t <= 13; t++) begin
         if (t == 4) sw_raw = 16'h0000;
         tick();
         n_cmp++;
         if (sw_clean !== 16'h0000 || sw_rise !== 16'h0000 || sw_fall !== 16'h0000) begin
            n_err++;
            $display("FAIL glitch edge %0d: clean=%h rise=%h fall=%h required all 0000", t, sw_clean, sw_rise, sw_fall);
         end
      end
      $display("test_glitch done");
   endtask

   task automatic test_walking_one();
      int rise_cnt [W];
      int fall_cnt [W];
      logic [W-1:0] prev;
      for (int i = 0; i < W; i++) begin rise_cnt[i] = 0; fall_cnt[i] = 0; end
      settle(16'h0000, 12);
      for (int b = 0; b < W; b++) begin
         prev = (b == 0) ? 16'h0000 : (16'h0001 << (b - 1));
         sw_raw = 16'h0001 << b;
         for (int t = 1; t <= 10; t++) begin
            tick();
            for (int i = 0; i < W; i++) begin
               rise_cnt[i] += int'(sw_rise[i]);
               fall_cnt[i] += int'(sw_fall[i]);
            end
            if (t == 5 || t == 6) begin
               n_cmp++;
               if (sw_clean !== ((t == 6) ? (16'h0001 << b) : prev)) begin
                  n_err++;
                  $display("FAIL walking_lag bit %0d edge %0d: sw_clean=%h required %h", b, t, sw_clean,
                           (t == 6) ? (16'h0001 << b) : prev);
               end
            end
         end
         $display("test_walking_one step sw_raw=%h sw_clean=%h", sw_raw, sw_clean);
      end
      for (int i = 0; i < W; i++) begin
         n_cmp++;
         if (rise_cnt[i] != 1 || fall_cnt[i] != ((i < W-1) ? 1 : 0)) begin
            n_err++;
            $display("FAIL walking_pulses bit %0d: rises=%0d falls=%0d required 1 and %0d",
                     i, rise_cnt[i], fall_cnt[i], (i < W-1) ? 1 : 0);
         end
      end
   endtask

   task automatic test_simultaneous();
      settle(16'h00FF, 12);
      sw_raw = 16'hFF00;
      for (int t = 1; t <= 6; t++) tick();
      n_cmp++;
      if (sw_rise !== 16'hFF00 || sw_fall !== 16'h00FF || sw_change !== 1'b1 || sw_clean !== 16'hFF00) begin
         n_err++;
         $display("FAIL simultaneous edge 6: clean=%h rise=%h fall=%h chg=%b required FF00 FF00 00FF 1",
                  sw_clean, sw_rise, sw_fall, sw_change);
      end
      $display("test_simultaneous done");
   endtask

   task automatic test_reset_mid_count();
      settle(16'h0000, 12);
      sw_raw = 16'h0010;
      for (int t = 1; t <= 4; t++) begin
         rst = (t == 4);
         tick();
         n_cmp++;
         if (sw_clean !== 16'h0000 || sw_rise !== 16'h0000 || sw_change !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid edge %0d: clean=%h rise=%h chg=%b required 0000 0000 0", t, sw_clean, sw_rise, sw_change);
         end
      end
      rst = 1'b0;
      for (int t = 1; t <= 6; t++) begin
         tick();
         n_cmp++;
         if (sw_clean !== ((t == 6) ? 16'h0010 : 16'h0000) || sw_rise !== ((t == 6) ? 16'h0010 : 16'h0000)) begin
            n_err++;
            $display("FAIL reset_mid_release edge %0d: clean=%h rise=%h", t, sw_clean, sw_rise);
         end
      end
      $display("test_reset_mid_count done");
   endtask

   task automatic test_random();
      int hold;
      for (int n = 0; n < 120; n++) begin
         sw_raw = 16'($urandom);
         rst    = ($urandom_range(0, 29) == 0);
         hold   = $urandom_range(1, 7);
         for (int t = 0; t < hold; t++) begin
            tick();
            rst = 1'b0;
            n_cmp++;
            if ({sw_clean, sw_rise, sw_fall, sw_change} !== {m_clean, m_rise, m_fall, m_change}
                || (sw_rise & sw_fall) !== 16'h0000) begin
               n_err++;
               $display("FAIL random_model txn %0d: got %h/%h/%h/%b required %h/%h/%h/%b", n,
                        sw_clean, sw_rise, sw_fall, sw_change, m_clean, m_rise, m_fall, m_change);
            end
         end
         $display("test_random txn %0d sw_raw=%h hold=%0d sw_clean=%h", n, sw_raw, hold, sw_clean);
      end
   endtask

   initial begin
      rst = 1'b1;
      sw_raw = '0;
      test_reset();
      test_single_step();
      test_glitch();
      test_walking_one();
      test_simultaneous();
      test_reset_mid_count();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
